// File: rtl/pcie_rx_st_buffer.sv
// pcie_rx_st_buffer
// Receive-side buffer sitting directly behind the Arria 10 PCIe hard IP
// Avalon-ST RX interface. Beats from the hard IP land in a first-word-fall-
// through FIFO that is deep enough to soak up the ready latency. The head of
// the FIFO is presented on a plain valid/ready stream together with the TLP
// header fields decoded from DW0, so the TLP-to-Wishbone logic never has to
// parse the header itself. SOP/EOP framing is checked on the way in and
// dropped beats are counted.
//
// Ports
//   clk_i, rst_i         core clock (coreclkout_hip), synchronous active-high reset
//   rx_st_*_i            Avalon-ST RX beat from the hard IP (data, sop, eop, err,
//                        valid, bar)
//   rx_st_ready_o        registered sink ready back to the hard IP
//   out_data/sop/eop/err head beat of the FIFO
//   out_bar/fmt/type/len header fields of the TLP the head beat belongs to
//   out_4dw_o            fmt[0], 4DW header
//   out_has_data_o       fmt[1], TLP carries payload
//   out_valid_o          FIFO not empty
//   out_ready_i          downstream takes the head beat
//   overflow_o           sticky, a beat arrived with no free entry
//   framing_err_o        sticky, SOP/EOP sequence violated
//   drop_cnt_o           number of dropped beats, saturating
//   clear_i              clears overflow_o, framing_err_o and drop_cnt_o

module pcie_rx_st_buffer #(
  parameter int DEPTH         = 16,
  parameter int READY_LATENCY = 2,
  parameter int DATA_W        = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_st_data_i,
  input  logic              rx_st_sop_i,
  input  logic              rx_st_eop_i,
  input  logic              rx_st_err_i,
  input  logic              rx_st_valid_i,
  input  logic [7:0]        rx_st_bar_i,
  output logic              rx_st_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sop_o,
  output logic              out_eop_o,
  output logic              out_err_o,
  output logic [7:0]        out_bar_o,
  output logic [2:0]        out_fmt_o,
  output logic [4:0]        out_type_o,
  output logic [9:0]        out_len_o,
  output logic              out_4dw_o,
  output logic              out_has_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              overflow_o,
  output logic              framing_err_o,
  output logic [15:0]       drop_cnt_o,
  input  logic              clear_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT     = (AW+1)'(DEPTH);
  localparam logic [AW:0] READY_THRESH = (AW+1)'(DEPTH - READY_LATENCY - 1);

  typedef enum logic {WR_IDLE, WR_PKT} wr_state_t;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [7:0]        mem_bar  [DEPTH];
  logic [DEPTH-1:0]  mem_sop;
  logic [DEPTH-1:0]  mem_eop;
  logic [DEPTH-1:0]  mem_err;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  logic rd_fire;
  logic wr_free;
  logic wr_fire;
  logic drop;
  logic ready_q;

  wr_state_t wr_state;
  logic      overflow_q;
  logic      framing_q;
  logic [15:0] drop_cnt_q;

  logic [2:0] hdr_fmt;
  logic [4:0] hdr_type;
  logic [9:0] hdr_len;
  logic [7:0] hdr_bar;

  logic [DATA_W-1:0] head_data;
  logic              head_sop;

  // A read frees its entry in the same cycle, so a full FIFO can still take
  // a beat while the head is leaving. Beats are written whenever valid,
  // because the hard IP may keep sending for READY_LATENCY cycles.
  assign out_valid_o = (count != '0);
  assign rd_fire     = out_valid_o & out_ready_i;
  assign wr_free     = (count < FULL_CNT) | rd_fire;
  assign wr_fire     = rx_st_valid_i & wr_free;
  assign drop        = rx_st_valid_i & ~wr_free;

  // Occupancy after this edge; ready is derived from it so that the hard IP
  // sees the throttle one cycle earlier than a count-based ready would give.
  always_comb begin
    count_next = count;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Entry storage carries no reset; only the pointers and count define
  // which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_data[wr_ptr] <= rx_st_data_i;
      mem_bar[wr_ptr]  <= rx_st_bar_i;
      mem_sop[wr_ptr]  <= rx_st_sop_i;
      mem_eop[wr_ptr]  <= rx_st_eop_i;
      mem_err[wr_ptr]  <= rx_st_err_i;
    end
  end

  // Pointers, occupancy and the registered ready. Ready resets high and is
  // masked by rst_i so it reads 0 while reset is held and 1 right after.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      ready_q <= (count_next <= READY_THRESH);
    end
  end

  assign rx_st_ready_o = ready_q & ~rst_i;

  // Framing checker. Every valid beat is checked, including ones that end
  // up dropped. A SOP inside a packet is flagged and then restarts framing
  // as a fresh packet. An event in the same cycle as clear_i wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state  <= WR_IDLE;
      framing_q <= 1'b0;
    end else begin
      if (clear_i) framing_q <= 1'b0;
      if (rx_st_valid_i) begin
        case (wr_state)
          WR_IDLE: begin
            if (!rx_st_sop_i)      framing_q <= 1'b1;
            else if (!rx_st_eop_i) wr_state  <= WR_PKT;
          end
          WR_PKT: begin
            if (rx_st_sop_i) begin
              framing_q <= 1'b1;
              wr_state  <= rx_st_eop_i ? WR_IDLE : WR_PKT;
            end else if (rx_st_eop_i) begin
              wr_state <= WR_IDLE;
            end
          end
          default: wr_state <= WR_IDLE;
        endcase
      end
    end
  end

  // Overflow flag and saturating drop counter; a drop in the clearing
  // cycle leaves the count at 1 rather than 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      overflow_q <= drop;
      drop_cnt_q <= {15'd0, drop};
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign overflow_o    = overflow_q;
  assign framing_err_o = framing_q;
  assign drop_cnt_o    = drop_cnt_q;

  // Head entry of the FIFO drives the beat outputs directly.
  assign head_data  = mem_data[rd_ptr];
  assign head_sop   = mem_sop[rd_ptr];
  assign out_data_o = head_data;
  assign out_sop_o  = head_sop;
  assign out_eop_o  = mem_eop[rd_ptr];
  assign out_err_o  = mem_err[rd_ptr];

  // Header of the TLP currently leaving the FIFO, captured when its SOP
  // beat transfers so the later beats of the same TLP show the same fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_fmt  <= '0;
      hdr_type <= '0;
      hdr_len  <= '0;
      hdr_bar  <= '0;
    end else if (rd_fire && head_sop) begin
      hdr_fmt  <= head_data[31:29];
      hdr_type <= head_data[28:24];
      hdr_len  <= head_data[9:0];
      hdr_bar  <= mem_bar[rd_ptr];
    end
  end

  // On a SOP head the fields come straight from the entry, otherwise from
  // the captured header, giving zero-latency decode on the first beat.
  assign out_fmt_o      = head_sop ? head_data[31:29]  : hdr_fmt;
  assign out_type_o     = head_sop ? head_data[28:24]  : hdr_type;
  assign out_len_o      = head_sop ? head_data[9:0]    : hdr_len;
  assign out_bar_o      = head_sop ? mem_bar[rd_ptr]   : hdr_bar;
  assign out_4dw_o      = out_fmt_o[0];
  assign out_has_data_o = out_fmt_o[1];

endmodule

// File: tb/tb_pcie_rx_st_buffer.sv
// Testbench for pcie_rx_st_buffer. Directed vectors from a table cover the
// single-beat read, the held multi-beat write, the SOP-inside-packet case
// and reset mid-packet; hand-written loops cover ready-latency backpressure
// and forced overflow; a long random run closes it out. A queue-based model
// of the buffer supplies the expected value of every output on every cycle.

module tb_pcie_rx_st_buffer;

  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] rx_st_data_i;
  logic        rx_st_sop_i, rx_st_eop_i, rx_st_err_i, rx_st_valid_i;
  logic [7:0]  rx_st_bar_i;
  logic        rx_st_ready_o;
  logic [63:0] out_data_o;
  logic        out_sop_o, out_eop_o, out_err_o;
  logic [7:0]  out_bar_o;
  logic [2:0]  out_fmt_o;
  logic [4:0]  out_type_o;
  logic [9:0]  out_len_o;
  logic        out_4dw_o, out_has_data_o, out_valid_o, out_ready_i;
  logic        overflow_o, framing_err_o;
  logic [15:0] drop_cnt_o;
  logic        clear_i;

  pcie_rx_st_buffer #(.DEPTH(DEPTH), .READY_LATENCY(RL), .DATA_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_st_data_i(rx_st_data_i), .rx_st_sop_i(rx_st_sop_i), .rx_st_eop_i(rx_st_eop_i),
    .rx_st_err_i(rx_st_err_i), .rx_st_valid_i(rx_st_valid_i), .rx_st_bar_i(rx_st_bar_i),
    .rx_st_ready_o(rx_st_ready_o),
    .out_data_o(out_data_o), .out_sop_o(out_sop_o), .out_eop_o(out_eop_o),
    .out_err_o(out_err_o), .out_bar_o(out_bar_o), .out_fmt_o(out_fmt_o),
    .out_type_o(out_type_o), .out_len_o(out_len_o), .out_4dw_o(out_4dw_o),
    .out_has_data_o(out_has_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .overflow_o(overflow_o), .framing_err_o(framing_err_o), .drop_cnt_o(drop_cnt_o),
    .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          valid;
    bit          sop;
    bit          eop;
    bit          err;
    logic [63:0] data;
    logic [7:0]  bar;
    bit          out_ready;
    bit          clear;
  } stim_t;

  typedef struct {
    stim_t      s;
    bit         chk_en;
    bit         exp_valid;
    logic [2:0] exp_fmt;
    logic [9:0] exp_len;
    bit         exp_4dw;
    bit         exp_hd;
    logic [7:0] exp_bar;
    bit         exp_frm;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    bit          err;
    logic [7:0]  bar;
  } beat_t;

  // Reference model state
  beat_t      mq[$];
  logic [2:0] m_fmt;
  logic [4:0] m_type;
  logic [9:0] m_len;
  logic [7:0] m_bar;
  bit         m_ovf, m_frm, m_in_pkt, m_ready;
  int         m_drop;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t st(bit r, bit v, bit s, bit e, logic [63:0] d, logic [7:0] b,
                               bit rdy, bit clr);
    stim_t x;
    x.rst = r; x.valid = v; x.sop = s; x.eop = e; x.err = 1'b0;
    x.data = d; x.bar = b; x.out_ready = rdy; x.clear = clr;
    return x;
  endfunction

  function automatic stim_t idle(bit rdy, bit clr);
    return st(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, rdy, clr);
  endfunction

  function automatic vec_t vx(stim_t s, bit c, bit ev, logic [2:0] f, logic [9:0] l,
                              bit d4, bit hd, logic [7:0] b, bit frm);
    vec_t v;
    v.s = s; v.chk_en = c; v.exp_valid = ev; v.exp_fmt = f; v.exp_len = l;
    v.exp_4dw = d4; v.exp_hd = hd; v.exp_bar = b; v.exp_frm = frm;
    return v;
  endfunction

  // Drive one cycle of inputs and advance the model to the state the DUT
  // will hold after the coming rising edge.
  task automatic applyStimulus(input stim_t s);
    bit    rd, full_before, drop_ev, frm_ev;
    beat_t b;
    rst_i         = s.rst;
    rx_st_valid_i = s.valid;
    rx_st_sop_i   = s.sop;
    rx_st_eop_i   = s.eop;
    rx_st_err_i   = s.err;
    rx_st_data_i  = s.data;
    rx_st_bar_i   = s.bar;
    out_ready_i   = s.out_ready;
    clear_i       = s.clear;
    if (s.rst) begin
      mq.delete();
      m_fmt = '0; m_type = '0; m_len = '0; m_bar = '0;
      m_ovf = 0; m_frm = 0; m_in_pkt = 0; m_drop = 0; m_ready = 1;
      return;
    end
    rd          = (mq.size() > 0) && s.out_ready;
    full_before = (mq.size() >= DEPTH);
    drop_ev     = 0;
    frm_ev      = 0;
    if (rd) begin
      if (mq[0].sop) begin
        m_fmt  = mq[0].data[31:29];
        m_type = mq[0].data[28:24];
        m_len  = mq[0].data[9:0];
        m_bar  = mq[0].bar;
      end
      void'(mq.pop_front());
    end
    if (s.valid) begin
      b.data = s.data; b.sop = s.sop; b.eop = s.eop; b.err = s.err; b.bar = s.bar;
      if (!full_before || rd) mq.push_back(b);
      else drop_ev = 1;
      if (m_in_pkt) begin
        if (s.sop) begin
          frm_ev   = 1;
          m_in_pkt = !s.eop;
        end else if (s.eop) begin
          m_in_pkt = 0;
        end
      end else begin
        if (s.sop) m_in_pkt = !s.eop;
        else       frm_ev = 1;
      end
    end
    if (s.clear) begin
      m_ovf  = drop_ev;
      m_frm  = frm_ev;
      m_drop = drop_ev ? 1 : 0;
    end else begin
      if (drop_ev) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (frm_ev) m_frm = 1;
    end
    m_ready = (mq.size() <= DEPTH - RL - 1);
  endtask

  // Compare every DUT output against the model state.
  task automatic checkOutput();
    beat_t h;
    logic [2:0] ef;
    chk("rx_ready", rx_st_ready_o, (rst_i == 1'b1) ? 1'b0 : m_ready);
    chk("out_valid", out_valid_o, mq.size() > 0);
    chk("overflow", overflow_o, m_ovf);
    chk("framing_err", framing_err_o, m_frm);
    chk("drop_cnt", drop_cnt_o, 64'(m_drop));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_data", out_data_o, h.data);
      chk("out_sop", out_sop_o, h.sop);
      chk("out_eop", out_eop_o, h.eop);
      chk("out_err", out_err_o, h.err);
      ef = h.sop ? h.data[31:29] : m_fmt;
      chk("out_fmt", out_fmt_o, ef);
      chk("out_type", out_type_o, h.sop ? h.data[28:24] : m_type);
      chk("out_len", out_len_o, h.sop ? h.data[9:0] : m_len);
      chk("out_bar", out_bar_o, h.sop ? h.bar : m_bar);
      chk("out_4dw", out_4dw_o, ef[0]);
      chk("out_has_data", out_has_data_o, ef[1]);
    end
  endtask

  task automatic step(input stim_t s);
    @(negedge clk_i);
    checkOutput();
    applyStimulus(s);
  endtask

  vec_t  vecs[$];
  stim_t s;
  bit    rdy_hist[$];
  bit    saw_low;
  int    rdy_pct;
  int    n_out;

  initial begin
    applyStimulus(st(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0));
    @(posedge clk_i);

    // Single 3DW MRd
    vecs.push_back(vx(st(1,0,0,0,64'h0,8'h0,0,0), 0, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(st(0,1,1,1,64'h0000_0001,8'h01,1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd0, 10'd1, 0, 0, 8'h01, 0));
    vecs.push_back(vx(idle(1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    // 4DW MWr over 3 beats, downstream stalled for 5 cycles
    vecs.push_back(vx(st(0,1,1,0,64'hAAAA_0000_6000_0004,8'h02,0,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(st(0,1,0,0,64'h1111_2222_3333_4444,8'hFF,0,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(st(0,1,0,1,64'h5555_6666_7777_8888,8'h00,0,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(0,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(0,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd3, 10'd4, 1, 1, 8'h02, 0));
    vecs.push_back(vx(idle(1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    // SOP inside a packet
    vecs.push_back(vx(st(0,1,1,0,64'h4000_0002,8'h04,1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(st(0,1,1,1,64'h2000_0005,8'h08,1,0), 1, 1, 3'd2, 10'd2, 0, 1, 8'h04, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd1, 10'd5, 1, 0, 8'h08, 1));
    vecs.push_back(vx(idle(1,1), 1, 0, 0, 0, 0, 0, 8'h00, 1));
    vecs.push_back(vx(idle(1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    // Reset after 2 of 4 beats, then a clean single-beat TLP
    vecs.push_back(vx(st(0,1,1,0,64'h4000_0003,8'h01,0,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(st(0,1,0,0,64'hDEAD_BEEF,8'h00,0,0), 1, 1, 3'd2, 10'd3, 0, 1, 8'h01, 0));
    vecs.push_back(vx(st(1,0,0,0,64'h0,8'h0,0,0), 1, 1, 3'd2, 10'd3, 0, 1, 8'h01, 0));
    vecs.push_back(vx(st(0,1,1,1,64'h0400_0001,8'h10,0,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(vx(idle(1,0), 1, 1, 3'd0, 10'd1, 0, 0, 8'h10, 0));
    vecs.push_back(vx(idle(1,0), 1, 0, 0, 0, 0, 0, 8'h00, 0));

    foreach (vecs[i]) begin
      @(negedge clk_i);
      checkOutput();
      if (vecs[i].chk_en) begin
        chk($sformatf("tbl%0d_valid", i), out_valid_o, vecs[i].exp_valid);
        chk($sformatf("tbl%0d_framing", i), framing_err_o, vecs[i].exp_frm);
        if (vecs[i].exp_valid) begin
          chk($sformatf("tbl%0d_fmt", i), out_fmt_o, vecs[i].exp_fmt);
          chk($sformatf("tbl%0d_len", i), out_len_o, vecs[i].exp_len);
          chk($sformatf("tbl%0d_4dw", i), out_4dw_o, vecs[i].exp_4dw);
          chk($sformatf("tbl%0d_has_data", i), out_has_data_o, vecs[i].exp_hd);
          chk($sformatf("tbl%0d_bar", i), out_bar_o, vecs[i].exp_bar);
        end
      end
      applyStimulus(vecs[i].s);
    end

    // Backpressure: a source honouring the 2-cycle ready latency
    step(st(1,0,0,0,64'h0,8'h0,0,0));
    saw_low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      checkOutput();
      if (mq.size() == DEPTH - RL - 1) chk("bp_ready_at_13", rx_st_ready_o, 1'b1);
      if (mq.size() == DEPTH - RL)     chk("bp_ready_at_14", rx_st_ready_o, 1'b0);
      if (!rx_st_ready_o && n > 0) saw_low = 1;
      rdy_hist.push_back(rx_st_ready_o);
      applyStimulus(st(0, (n >= 2) && rdy_hist[n-2], 1, 1, 64'(n), 8'h3, 0, 0));
    end
    @(negedge clk_i);
    checkOutput();
    chk("bp_saw_ready_low", saw_low, 1'b1);
    chk("bp_no_drop", drop_cnt_o, 16'd0);
    chk("bp_no_overflow", overflow_o, 1'b0);
    applyStimulus(st(1,0,0,0,64'h0,8'h0,0,0));

    // Forced overflow: 20 beats into an empty FIFO with reads blocked
    for (int n = 0; n < 20; n++)
      step(st(0, 1, 1, 1, 64'h100 + 64'(n), 8'h5, 0, 0));
    @(negedge clk_i);
    checkOutput();
    chk("ovf_drop_cnt", drop_cnt_o, 16'd4);
    chk("ovf_flag", overflow_o, 1'b1);
    chk("ovf_full_ready", rx_st_ready_o, 1'b0);
    // write and read together while full
    applyStimulus(st(0, 1, 1, 1, 64'h200, 8'h6, 1, 0));
    @(negedge clk_i);
    checkOutput();
    chk("full_rw_no_drop", drop_cnt_o, 16'd4);
    applyStimulus(idle(0, 1));
    @(negedge clk_i);
    checkOutput();
    chk("clear_drop_cnt", drop_cnt_o, 16'd0);
    chk("clear_overflow", overflow_o, 1'b0);
    applyStimulus(idle(0, 0));
    n_out = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      checkOutput();
      if (out_valid_o) n_out++;
      applyStimulus(idle(1, 0));
    end
    chk("ovf_beats_stored", n_out, 16);

    // Random traffic, protocol-clean and otherwise
    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) rdy_pct = $urandom_range(10, 100);
      s.rst       = ($urandom_range(0, 299) == 0);
      s.valid     = ($urandom_range(0, 99) < 70);
      s.sop       = $urandom_range(0, 1);
      s.eop       = $urandom_range(0, 1);
      s.err       = ($urandom_range(0, 9) == 0);
      s.data      = {$urandom(), $urandom()};
      s.bar       = 8'($urandom_range(0, 255));
      s.out_ready = ($urandom_range(1, 100) <= rdy_pct);
      s.clear     = ($urandom_range(0, 59) == 0);
      step(s);
    end
    @(negedge clk_i);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
